// File: rtl/serial_pattern_tx_pkg.sv
// serial_pattern_tx_pkg: states, defaults and copy length for serial_pattern_tx (SERIAL_PATTERN_TX_PARITY_EN adds a parity bit per copy).
package serial_pattern_tx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP = 2;
  function automatic int copy_len(input int w);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction
endpackage

// File: rtl/serial_pattern_tx_piso_shreg.sv
// piso_shreg: parallel-load, shift-left register with zero fill; msb is the serial output.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic         msb_o
);
  logic [W-1:0] sr_q;
  always_ff @(posedge clk)
    sr_q <= rst ? '0 : load_i ? d_i : shift_i ? {sr_q[W-2:0], 1'b0} : sr_q;
  assign msb_o = sr_q[W-1];
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends a pattern MSB first N times with GAP idle cycles between copies, then pulses done.
// SERIAL_PATTERN_TX_PARITY_EN appends the even parity of the pattern to every copy.
module serial_pattern_tx import serial_pattern_tx_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_i,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int LEN = copy_len(WIDTH);
  localparam int CW  = $clog2((LEN > GAP ? LEN : GAP) + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] pat_q, pat_d, pat_src;
  logic [LEN-1:0] load_val;
  logic accept, load, shift, done_q, done_d, out_valid_q;
  assign start_ready = (state_q == S_IDLE) && !rst;
  assign accept = start_valid && start_ready;
  assign pat_src = accept ? pattern : pat_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  assign load_val = {pat_src, ^pat_src};
`else
  assign load_val = pat_src;
`endif
  // rep_q counts copies still to send, including the one in flight
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rep_d = rep_q;
    pat_d = pat_q;
    load = 1'b0;
    shift = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_SHIFT;
        cnt_d = '0;
        rep_d = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
        pat_d = pattern;
        load = 1'b1;
      end
      S_SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LEN - 1)) begin
          cnt_d = '0;
          if (rep_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d = 1'b1;
          end else begin
            rep_d = rep_q - CNT_W'(1);
            if (GAP == 0) load = 1'b1;
            else state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP - 1)) begin
          state_d = S_SHIFT;
          cnt_d = '0;
          load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? S_IDLE : state_d;
    cnt_q <= rst ? '0 : cnt_d;
    rep_q <= rst ? '0 : rep_d;
    pat_q <= rst ? '0 : pat_d;
    done_q <= rst ? 1'b0 : done_d;
    out_valid_q <= rst ? 1'b0 : (state_d == S_SHIFT);
  end
  // the register empties itself by the end of a copy, so out idles at 0
  piso_shreg #(.W(LEN)) u_sr (
    .clk(clk), .rst(rst), .load_i(load), .shift_i(shift), .d_i(load_val), .msb_o(out)
  );
  assign out_valid = out_valid_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed and random transfers checked cycle by cycle against a waveform queue model.
module tb_serial_pattern_tx;
  localparam int W = 8, CW = 4, G = 2;
  logic clk = 1'b0, rst = 1'b1, start_valid = 1'b0;
  logic start_ready, out, out_valid, busy, done;
  logic [W-1:0] pattern = '0;
  logic [CW-1:0] repeat_i = '0;
  int total = 0, bad = 0;
  typedef struct packed {logic o; logic v; logic b; logic d;} exp_t;
  exp_t q[$];
  exp_t cur;
  always #5 clk = ~clk;
  serial_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP(G)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .repeat_i(repeat_i), .out(out), .out_valid(out_valid),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic load_model(input logic [W-1:0] p, input logic [CW-1:0] r);
    int n = (r == 0) ? 1 : int'(r);
    for (int c = 0; c < n; c++) begin
      for (int i = W - 1; i >= 0; i--) q.push_back('{p[i], 1'b1, 1'b1, 1'b0});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      q.push_back('{^p, 1'b1, 1'b1, 1'b0});
`endif
      if (c < n - 1) for (int g = 0; g < G; g++) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
  endtask
  task automatic step(input logic sv, input logic [W-1:0] p, input logic [CW-1:0] r, input logic rs);
    logic acc;
    @(negedge clk);
    start_valid = sv;
    pattern = p;
    repeat_i = r;
    rst = rs;
    #1;
    chk("out", out, cur.o);
    chk("out_valid", out_valid, cur.v);
    chk("busy", busy, cur.b);
    chk("done", done, cur.d);
    chk("start_ready", start_ready, !cur.b && !rs);
    acc = sv && !cur.b && !rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      cur = '0;
    end else begin
      if (acc) load_model(p, r);
      cur = (q.size() > 0) ? q.pop_front() : '0;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), CW'($urandom), 1'b0);
  endtask
  initial begin
    cur = '0;
    repeat (2) @(posedge clk);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 8'hE7, 4'd1, 1'b0);
    idle(12);
    step(1'b1, 8'hA5, 4'd3, 1'b0);
    idle(32);
    step(1'b1, 8'h07, 4'd0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 8'h3C, 4'd2, 1'b0);
    idle(24);
    step(1'b1, 8'hA5, 4'd2, 1'b0);
    idle(4);
    step(1'b1, 8'hFF, 4'd1, 1'b1);
    idle(4);
    step(1'b1, 8'h81, 4'd15, 1'b0);
    idle(160);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, W'($urandom), CW'($urandom), $urandom_range(0, 199) == 0);
    idle(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
